commu_push_pk: RTL and testbench

// - Parametrised packet pusher: reads len_pkg bytes from the frame buffer and packs BPW bytes per tx word.
// - Fires one tx word at a time and waits for done_tx before the next.
// - Handles packets whose length is not a multiple of BPW, and reports valid bytes per word.
// - Sits between the packet buffer and the commu tx serialiser in commu_top.

---
 rtl/commu_push_pk.sv | 201 ++++++++++++++++++++
 tb/tb_commu_push_pk.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commu_push_pk.sv
// commu_push_pk: packet pusher between the frame buffer and the commu tx
// serialiser. Reads len_pkg bytes, packs BPW bytes per tx word (first byte
// in the MS byte), fires one word at a time and waits for done_tx.
// Optional feature macro: COMMU_PUSH_TIMEOUT_EN (done_tx timeout -> ERR).
module commu_push_pk #(
  parameter int DW    = 8,
  parameter int BPW   = 2,
  parameter int LEN_W = 16,
  parameter int TO_W  = 16
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic                       fire_push,
  output logic                       done_push,
  output logic                       err_push,
  input  logic [LEN_W-1:0]           len_pkg,
  input  logic [TO_W-1:0]            to_lim,
  output logic                       buf_rd,
  output logic                       buf_frm,
  input  logic [DW-1:0]              buf_q,
  output logic                       fire_tx,
  output logic [DW*BPW-1:0]          data_tx,
  output logic [$clog2(BPW+1)-1:0]   nb_tx,
  input  logic                       done_tx
);

  localparam int W    = DW * BPW;
  localparam int NB_W = $clog2(BPW + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_READ, ST_CAPT, ST_FIRE, ST_WAIT, ST_NEXT, ST_DONE, ST_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [NB_W-1:0]   n_q, n_d;
  logic [NB_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [W-1:0]      sh_q, sh_d;
  logic              cap_q, cap_d;
  logic              done_push_q, done_push_d;
  logic              buf_rd_q, buf_rd_d;
  logic              buf_frm_q, buf_frm_d;
  logic              fire_tx_q, fire_tx_d;
  logic [W-1:0]      data_tx_q, data_tx_d;
  logic [NB_W-1:0]   nb_tx_q, nb_tx_d;
  logic [NB_W-1:0]   n_calc;

`ifdef COMMU_PUSH_TIMEOUT_EN
  logic              err_push_q, err_push_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`else
  logic              unused_to_lim;
  assign unused_to_lim = ^to_lim;
`endif

  // Bytes for the next word: a full word unless fewer than BPW remain.
  always_comb begin
    n_calc = (rem_q >= LEN_W'(BPW)) ? NB_W'(BPW) : rem_q[NB_W-1:0];
  end

  // Next-state and next-output computation for the whole pusher.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    n_d       = n_q;
    rd_cnt_d  = rd_cnt_q;
    sh_d      = sh_q;
    cap_d     = buf_rd_q;
    fire_tx_d = 1'b0;
    data_tx_d = data_tx_q;
    nb_tx_d   = nb_tx_q;
`ifdef COMMU_PUSH_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    if (cap_q) begin
      sh_d = (sh_q << DW) | W'(buf_q);
    end
    case (state_q)
      ST_IDLE: begin
        if (fire_push) begin
          state_d = ST_LOAD;
          rem_d   = len_pkg;
        end
      end
      ST_LOAD, ST_NEXT: begin
        if (rem_q == '0) begin
          state_d   = ST_DONE;
          data_tx_d = '0;
          nb_tx_d   = '0;
        end else begin
          state_d  = ST_READ;
          n_d      = n_calc;
          rd_cnt_d = '0;
          sh_d     = '0;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == n_q - 1'b1) begin
          state_d = ST_CAPT;
          rem_d   = rem_q - LEN_W'(n_q);
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_CAPT: begin
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d   = ST_WAIT;
        fire_tx_d = 1'b1;
        nb_tx_d   = n_q;
        data_tx_d = sh_q;
        for (int i = 0; i < BPW; i++) begin
          if (i < BPW - int'(n_q)) begin
            data_tx_d = data_tx_d << DW;
          end
        end
`ifdef COMMU_PUSH_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (done_tx && !fire_tx_q) begin
          state_d = ST_NEXT;
`ifdef COMMU_PUSH_TIMEOUT_EN
        end else if ((to_lim != '0) && (to_cnt_q + 1'b1 == to_lim)) begin
          state_d   = ST_ERR;
          data_tx_d = '0;
          nb_tx_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_push_d = (state_d == ST_DONE);
    buf_rd_d    = (state_d == ST_READ);
    buf_frm_d   = (state_d != ST_IDLE);
`ifdef COMMU_PUSH_TIMEOUT_EN
    err_push_d  = (state_d == ST_ERR);
`endif
  end

  // State, counters and registered outputs; synchronous reset clears all.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      n_q         <= '0;
      rd_cnt_q    <= '0;
      sh_q        <= '0;
      cap_q       <= 1'b0;
      done_push_q <= 1'b0;
      buf_rd_q    <= 1'b0;
      buf_frm_q   <= 1'b0;
      fire_tx_q   <= 1'b0;
      data_tx_q   <= '0;
      nb_tx_q     <= '0;
`ifdef COMMU_PUSH_TIMEOUT_EN
      err_push_q  <= 1'b0;
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      n_q         <= n_d;
      rd_cnt_q    <= rd_cnt_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      done_push_q <= done_push_d;
      buf_rd_q    <= buf_rd_d;
      buf_frm_q   <= buf_frm_d;
      fire_tx_q   <= fire_tx_d;
      data_tx_q   <= data_tx_d;
      nb_tx_q     <= nb_tx_d;
`ifdef COMMU_PUSH_TIMEOUT_EN
      err_push_q  <= err_push_d;
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign done_push = done_push_q;
  assign buf_rd    = buf_rd_q;
  assign buf_frm   = buf_frm_q;
  assign fire_tx   = fire_tx_q;
  assign data_tx   = data_tx_q;
  assign nb_tx     = nb_tx_q;
`ifdef COMMU_PUSH_TIMEOUT_EN
  assign err_push  = err_push_q;
`else
  assign err_push  = 1'b0;
`endif

endmodule

// File: tb/tb_commu_push_pk.sv
// tb_commu_push_pk: scoreboard bench for commu_push_pk (BPW=2). Expected
// words are queued when a packet is launched and popped on each fire_tx.
module tb_commu_push_pk;

  localparam int DW    = 8;
  localparam int BPW   = 2;
  localparam int LEN_W = 16;
  localparam int TO_W  = 16;
  localparam int W     = DW * BPW;
  localparam int NB_W  = $clog2(BPW + 1);
  localparam int BUDGET = 400;

  typedef struct {
    logic [W-1:0]    data;
    logic [NB_W-1:0] nb;
  } exp_t;

  logic              clk_sys = 1'b0;
  logic              rst = 1'b1;
  logic              fire_push = 1'b0;
  logic              done_push;
  logic              err_push;
  logic [LEN_W-1:0]  len_pkg = '0;
  logic [TO_W-1:0]   to_lim = '0;
  logic              buf_rd;
  logic              buf_frm;
  logic [DW-1:0]     buf_q;
  logic              fire_tx;
  logic [W-1:0]      data_tx;
  logic [NB_W-1:0]   nb_tx;
  logic              done_tx = 1'b0;

  logic [DW-1:0]     mem [0:63];
  int                rd_ptr;
  logic              ptr_clr = 1'b0;
  exp_t              sb [$];
  int                vectors = 0;
  int                miscompares = 0;

  commu_push_pk #(.DW(DW), .BPW(BPW), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clk_sys(clk_sys), .rst(rst), .fire_push(fire_push), .done_push(done_push),
    .err_push(err_push), .len_pkg(len_pkg), .to_lim(to_lim), .buf_rd(buf_rd),
    .buf_frm(buf_frm), .buf_q(buf_q), .fire_tx(fire_tx), .data_tx(data_tx),
    .nb_tx(nb_tx), .done_tx(done_tx)
  );

  always #5 clk_sys = ~clk_sys;

  // Buffer model: data for a read strobe appears the following cycle.
  always @(posedge clk_sys) begin
    if (ptr_clr) begin
      rd_ptr <= 0;
    end else if (buf_rd) begin
      buf_q  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Launch one packet and follow it to done_push/err_push, checking each
  // fired word against the scoreboard, including when it appears.
  task automatic push_packet(input int len, input int gap, input bit noise,
                             input int stop_words, output int words,
                             output int dones, output int rds,
                             output int errs, output int err_rel);
    int   cyc, cnt, exp_fire, exp_done, last_fire, n;
    bit   fin;
    exp_t e;
    logic [W-1:0] d;
    words = 0; dones = 0; rds = 0; errs = 0; err_rel = -1;
    sb.delete();
    for (int w = 0; w * BPW < len; w++) begin
      n = (len - w * BPW >= BPW) ? BPW : len - w * BPW;
      d = '0;
      for (int k = 0; k < n; k++) d = d | (W'(mem[w * BPW + k]) << (DW * (BPW - 1 - k)));
      e.data = d;
      e.nb   = NB_W'(n);
      sb.push_back(e);
    end
    exp_fire = (sb.size() > 0) ? 4 + int'(sb[0].nb) : -1;
    exp_done = (sb.size() > 0) ? -1 : 2;
    len_pkg = LEN_W'(len);
    @(negedge clk_sys);
    ptr_clr = 1'b1;
    @(negedge clk_sys);
    ptr_clr   = 1'b0;
    fire_push = 1'b1;
    done_tx   = noise;
    cyc = 0; cnt = 0; last_fire = -1; fin = 1'b0;
    while (!fin && cyc < BUDGET) begin
      @(negedge clk_sys);
      cyc++;
      fire_push = 1'b0;
      len_pkg   = LEN_W'(cyc * 7);
      if (cnt > 0) begin
        cnt--;
        done_tx = (cnt == 0);
      end else begin
        done_tx = noise;
      end
      if (buf_rd) rds++;
      if (fire_tx) begin
        words++;
        last_fire = cyc;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_fire_tx: got fire_tx at cycle %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          vectors += 2;
          if (data_tx !== e.data) begin
            miscompares++;
            $display("[TB] FAIL data_tx word %0d: got %h, required %h", words, data_tx, e.data);
          end
          if (nb_tx !== e.nb) begin
            miscompares++;
            $display("[TB] FAIL nb_tx word %0d: got %0d, required %0d", words, nb_tx, e.nb);
          end
          if (cyc !== exp_fire) begin
            miscompares++;
            $display("[TB] FAIL fire_timing word %0d: got cycle %0d, required %0d", words, cyc, exp_fire);
          end
        end
        if (gap >= 0) begin
          cnt = gap;
          if (sb.size() > 0) exp_fire = cyc + gap + 4 + int'(sb[0].nb);
          else exp_done = cyc + gap + 2;
        end
        if (noise) fire_push = 1'b1;
        if (stop_words > 0 && words == stop_words) fin = 1'b1;
      end
      if (err_push) begin
        errs++;
        err_rel = cyc - last_fire;
        fin = 1'b1;
      end
      if (done_push) begin
        dones++;
        vectors++;
        if (cyc !== exp_done) begin
          miscompares++;
          $display("[TB] FAIL done_timing: got cycle %0d, required %0d", cyc, exp_done);
        end
        fin = 1'b1;
      end
    end
    fire_push = 1'b0;
    done_tx   = 1'b0;
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL packet_timeout: got no end after %0d cycles, required done_push or err_push", BUDGET);
    end
  endtask

  // All registered outputs at their reset values.
  task automatic check_idle_outputs(input string tag);
    vectors += 7;
    if (done_push !== 1'b0) begin miscompares++; $display("[TB] FAIL %s done_push: got %b, required 0", tag, done_push); end
    if (err_push  !== 1'b0) begin miscompares++; $display("[TB] FAIL %s err_push: got %b, required 0", tag, err_push); end
    if (buf_rd    !== 1'b0) begin miscompares++; $display("[TB] FAIL %s buf_rd: got %b, required 0", tag, buf_rd); end
    if (buf_frm   !== 1'b0) begin miscompares++; $display("[TB] FAIL %s buf_frm: got %b, required 0", tag, buf_frm); end
    if (fire_tx   !== 1'b0) begin miscompares++; $display("[TB] FAIL %s fire_tx: got %b, required 0", tag, fire_tx); end
    if (data_tx   !== '0)   begin miscompares++; $display("[TB] FAIL %s data_tx: got %h, required 0", tag, data_tx); end
    if (nb_tx     !== '0)   begin miscompares++; $display("[TB] FAIL %s nb_tx: got %0d, required 0", tag, nb_tx); end
  endtask

  task automatic check_counts(input string tag, input int words, input int exp_words,
                              input int dones, input int exp_dones,
                              input int rds, input int exp_rds);
    vectors += 3;
    if (words !== exp_words) begin miscompares++; $display("[TB] FAIL %s word_count: got %0d, required %0d", tag, words, exp_words); end
    if (dones !== exp_dones) begin miscompares++; $display("[TB] FAIL %s done_count: got %0d, required %0d", tag, dones, exp_dones); end
    if (rds   !== exp_rds)   begin miscompares++; $display("[TB] FAIL %s buf_rd_count: got %0d, required %0d", tag, rds, exp_rds); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_full_words();
    int words, dones, rds, errs, err_rel;
    for (int i = 0; i < 6; i++) mem[i] = DW'(8'h11 + i);
    push_packet(6, 3, 1'b0, 0, words, dones, rds, errs, err_rel);
    check_counts("full", words, 3, dones, 1, rds, 6);
  endtask

  task automatic test_short_tail();
    int words, dones, rds, errs, err_rel;
    for (int i = 0; i < 5; i++) mem[i] = DW'(8'hA1 + i);
    push_packet(5, 3, 1'b0, 0, words, dones, rds, errs, err_rel);
    check_counts("short", words, 3, dones, 1, rds, 5);
  endtask

  task automatic test_zero_len();
    int words, dones, rds, errs, err_rel;
    push_packet(0, 3, 1'b0, 0, words, dones, rds, errs, err_rel);
    check_counts("zero", words, 0, dones, 1, rds, 0);
  endtask

  task automatic test_back_to_back_noise();
    int words, dones, rds, errs, err_rel;
    for (int i = 0; i < 6; i++) mem[i] = DW'(8'h31 + i);
    push_packet(6, 3, 1'b1, 0, words, dones, rds, errs, err_rel);
    check_counts("noise", words, 3, dones, 1, rds, 6);
  endtask

  task automatic test_mid_reset();
    int words, dones, rds, errs, err_rel;
    for (int i = 0; i < 8; i++) mem[i] = DW'(8'h41 + i);
    push_packet(8, 3, 1'b0, 2, words, dones, rds, errs, err_rel);
    rst = 1'b1;
    @(negedge clk_sys);
    check_idle_outputs("midreset");
    rst = 1'b0;
    push_packet(8, 2, 1'b0, 0, words, dones, rds, errs, err_rel);
    check_counts("restart", words, 4, dones, 1, rds, 8);
  endtask

`ifdef COMMU_PUSH_TIMEOUT_EN
  task automatic test_timeout();
    int words, dones, rds, errs, err_rel;
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'h51 + i);
    to_lim = TO_W'(10);
    push_packet(4, -1, 1'b0, 0, words, dones, rds, errs, err_rel);
    check_counts("timeout", words, 1, dones, 0, rds, 2);
    vectors += 2;
    if (errs !== 1) begin miscompares++; $display("[TB] FAIL err_count: got %0d, required 1", errs); end
    if (err_rel !== 10) begin miscompares++; $display("[TB] FAIL err_timing: got %0d, required 10", err_rel); end
    @(negedge clk_sys);
    check_idle_outputs("after_err");
    to_lim = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_words();
    test_short_tail();
    test_zero_len();
    test_back_to_back_noise();
    test_mid_reset();
`ifdef COMMU_PUSH_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
